// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch address with exception/redirect/stall
// priority and a circular return-address stack predicting return targets.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4,
  localparam int              PTR_W     = $clog2(RAS_DEPTH),
  localparam int              CNT_W     = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pc_write_i,
  input  logic             exc_i,
  input  logic [WIDTH-1:0] exc_vec_i,
  input  logic             redir_i,
  input  logic [WIDTH-1:0] redir_target_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_next_o,
  output logic [CNT_W-1:0] ras_count_o,
  output logic             ras_empty_o,
  output logic             ras_full_o
);

  logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, waddr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active, empty, full, we;

  assign pc_inc = pc_q + WIDTH'(INC);
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(RAS_DEPTH));
  assign active = pc_write_i && !exc_i && !redir_i;

  always_comb begin
    pc_d = pc_inc;
    if (exc_i)                pc_d = exc_vec_i;
    else if (redir_i)         pc_d = redir_target_i;
    else if (!pc_write_i)     pc_d = pc_q;
    else if (ret_i && !empty) pc_d = ras_q[ptr_q];
  end

  // ptr_q always indexes the current top; a push writes one slot above it,
  // so a push on a full stack silently overwrites the oldest entry.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    we    = 1'b0;
    waddr = ptr_q + PTR_W'(1);
    if (exc_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (active) begin
      if (call_i && (!ret_i || empty)) begin
        we    = 1'b1;
        ptr_d = ptr_q + PTR_W'(1);
        cnt_d = full ? cnt_q : cnt_q + CNT_W'(1);
      end else if (call_i && ret_i) begin
        we    = 1'b1;
        waddr = ptr_q;
      end else if (ret_i && !empty) begin
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries carry no reset; validity is tracked solely by cnt_q.
  always_ff @(posedge clk_i) begin
    if (we) ras_q[waddr] <= pc_inc;
  end

  assign pc_o        = pc_q;
  assign pc_next_o   = pc_d;
  assign ras_count_o = cnt_q;
  assign ras_empty_o = empty;
  assign ras_full_o  = full;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed test-plan steps followed by random
// traffic, compared against a queue-based model of the return stack.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pw = 1'b1, exc = 1'b0, redir = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] ev = '0, tgt = '0;
  logic [31:0] pc, pc_next;
  logic [2:0]  cnt;
  logic        empty, full;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  pc_unit #(.WIDTH(32), .RESET_VEC(32'h0), .INC(4), .RAS_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .pc_write_i(pw), .exc_i(exc), .exc_vec_i(ev),
    .redir_i(redir), .redir_target_i(tgt), .call_i(call), .ret_i(ret),
    .pc_o(pc), .pc_next_o(pc_next), .ras_count_o(cnt),
    .ras_empty_o(empty), .ras_full_o(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next();
    if (exc)                          return ev;
    if (redir)                        return tgt;
    if (!pw)                          return m_pc;
    if (ret && m_ras.size() > 0)      return m_ras[m_ras.size()-1];
    return m_pc + 32'd4;
  endfunction

  task automatic model_update(input logic [31:0] nxt);
    if (exc) m_ras.delete();
    else if (pw && !redir) begin
      if (call && ret && m_ras.size() > 0) m_ras[m_ras.size()-1] = m_pc + 32'd4;
      else if (call) begin
        if (m_ras.size() == 4) void'(m_ras.pop_front());
        m_ras.push_back(m_pc + 32'd4);
      end else if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
    end
    m_pc = nxt;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".pc"},    pc, m_pc);
    chk({tag, ".cnt"},   {29'b0, cnt}, m_ras.size());
    chk({tag, ".empty"}, {31'b0, empty}, {31'b0, m_ras.size() == 0});
    chk({tag, ".full"},  {31'b0, full}, {31'b0, m_ras.size() == 4});
  endtask

  // One cycle: drive inputs, check the combinational next-PC, clock, check state.
  task automatic step(input string tag, input logic i_pw, input logic i_exc,
                      input logic [31:0] i_ev, input logic i_redir,
                      input logic [31:0] i_tgt, input logic i_call, input logic i_ret);
    logic [31:0] nxt;
    pw = i_pw; exc = i_exc; ev = i_ev; redir = i_redir; tgt = i_tgt;
    call = i_call; ret = i_ret;
    #1;
    nxt = model_next();
    chk({tag, ".pc_next"}, pc_next, nxt);
    @(posedge clk);
    #1;
    model_update(nxt);
    check_state(tag);
  endtask

  task automatic seq(input string tag);
    step(tag, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic jump(input string tag, input logic [31:0] a);
    step(tag, 1, 0, 0, 1, a, 0, 0);
  endtask

  initial begin
    // Asynchronous reset asserted mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("rst_async.pc", pc, 32'h0);
    chk("rst_async.empty", {31'b0, empty}, 32'd1);
    chk("rst_async.full", {31'b0, full}, 32'd0);
    chk("rst_async.cnt", {29'b0, cnt}, 32'd0);
    m_pc = 32'h0;
    m_ras.delete();
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;

    seq("seq1"); seq("seq2"); seq("seq3");
    chk("seq.pc_c", pc, 32'hC);

    jump("to_top", 32'hFFFF_FFFC);
    seq("wrap");
    chk("wrap.zero", pc, 32'h0);

    jump("to_40", 32'h40);
    step("stall1", 0, 0, 0, 0, 0, 0, 0);
    step("stall2", 0, 0, 0, 0, 0, 1, 0);
    step("stall3", 0, 0, 0, 0, 0, 0, 0);
    chk("stall.hold", pc, 32'h40);
    step("stall_redir", 0, 0, 0, 1, 32'h100, 0, 0);
    chk("stall_redir.pc", pc, 32'h100);
    step("exc_redir", 1, 1, 32'h8000_0180, 1, 32'h200, 0, 0);
    chk("exc_redir.pc", pc, 32'h8000_0180);

    jump("to_10", 32'h10);
    step("call10", 1, 0, 0, 0, 0, 1, 0);
    chk("call10.cnt", {29'b0, cnt}, 32'd1);
    jump("to_200", 32'h200);
    step("ret200", 1, 0, 0, 0, 0, 0, 1);
    chk("ret200.pc", pc, 32'h14);
    chk("ret200.cnt", {29'b0, cnt}, 32'd0);
    jump("to_300", 32'h300);
    step("ret_empty", 1, 0, 0, 0, 0, 0, 1);
    chk("ret_empty.pc", pc, 32'h304);

    for (int i = 0; i < 5; i++) begin
      jump("ovf_jump", 32'(i) * 32'h10);
      step("ovf_call", 1, 0, 0, 0, 0, 1, 0);
    end
    chk("ovf.full", {31'b0, full}, 32'd1);
    chk("ovf.cnt", {29'b0, cnt}, 32'd4);
    jump("to_500", 32'h500);
    step("ovf_ret1", 1, 0, 0, 0, 0, 0, 1);  chk("ovf_ret1.pc", pc, 32'h44);
    step("ovf_ret2", 1, 0, 0, 0, 0, 0, 1);  chk("ovf_ret2.pc", pc, 32'h34);
    step("ovf_ret3", 1, 0, 0, 0, 0, 0, 1);  chk("ovf_ret3.pc", pc, 32'h24);
    step("ovf_ret4", 1, 0, 0, 0, 0, 0, 1);  chk("ovf_ret4.pc", pc, 32'h14);
    step("ovf_ret5", 1, 0, 0, 0, 0, 0, 1);  chk("ovf_ret5.pc", pc, 32'h18);

    jump("to_10b", 32'h10);
    step("call10b", 1, 0, 0, 0, 0, 1, 0);
    jump("to_50", 32'h50);
    step("callret", 1, 0, 0, 0, 0, 1, 1);
    chk("callret.pc", pc, 32'h14);
    chk("callret.cnt", {29'b0, cnt}, 32'd1);
    jump("to_900", 32'h900);
    step("ret_top", 1, 0, 0, 0, 0, 0, 1);
    chk("ret_top.pc", pc, 32'h54);
    step("callret_empty", 1, 0, 0, 0, 0, 1, 1);
    chk("callret_empty.cnt", {29'b0, cnt}, 32'd1);
    step("exc_clear", 1, 1, 32'h180, 0, 0, 1, 0);
    chk("exc_clear.empty", {31'b0, empty}, 32'd1);
    step("call_stall", 0, 0, 0, 0, 0, 1, 0);
    chk("call_stall.cnt", {29'b0, cnt}, 32'd0);

    // Random traffic, with one asynchronous reset dropped in midway
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 rst = 1'b1;
        #1;
        m_pc = 32'h0;
        m_ras.delete();
        check_state("rnd_rst");
        @(posedge clk);
        #3 rst = 1'b0;
      end
      step("rnd", $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0,
           $urandom() & 32'hFFFF_FFFC, $urandom_range(7, 0) == 0,
           $urandom() & 32'hFFFF_FFFC, $urandom_range(2, 0) == 0,
           $urandom_range(2, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined MIPS core, the next generation of the plain loadable PC register. It holds the fetch address and advances it sequentially. It accepts exception and branch/jump redirects with fixed priority, and honours the hazard unit's write-enable (stall). An internal circular return-address stack (RAS) predicts return targets at fetch. It sits at the front of IF, feeding instruction memory and the IF/ID register.

## Interface
- WIDTH, 32, address width in bits
- RESET_VEC, 0, value loaded into the PC on reset
- INC, 4, sequential increment in bytes
- RAS_DEPTH, 4, RAS entries; a power of two, at least 2
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- pc_write_i  in  1  hazard-unit enable; 0 = stall
- exc_i  in  1  exception redirect request
- exc_vec_i  in  WIDTH  exception handler address
- redir_i  in  1  branch/jump resolved-taken redirect from EX
- redir_target_i  in  WIDTH  redirect target
- call_i  in  1  instruction at pc_o is a call (jal/jalr)
- ret_i  in  1  instruction at pc_o is a return (jr $ra)
- pc_o  out  WIDTH  registered fetch address
- pc_next_o  out  WIDTH  combinational value pc_o takes at the next edge
- ras_count_o  out  clog2(RAS_DEPTH)+1  valid RAS entries
- ras_empty_o  out  1  ras_count_o == 0
- ras_full_o  out  1  ras_count_o == RAS_DEPTH

## Operation
- Next-PC priority, highest first:
  - exc_i: exc_vec_i
  - redir_i: redir_target_i
  - pc_write_i == 0: hold pc_o
  - ret_i with RAS non-empty: RAS top
  - otherwise: pc_o + INC
- exc_i and redir_i update the PC even when pc_write_i == 0. A redirect never stalls.
- All arithmetic is modulo 2^WIDTH. pc_o + INC wraps silently at the top of the address space.
- RAS activity is enabled only when pc_write_i == 1, exc_i == 0 and redir_i == 0. Call this "active".
  - call_i only: push pc_o + INC. When full, overwrite the oldest entry (circular). The write pointer advances and the count saturates at RAS_DEPTH.
  - ret_i only, non-empty: pop. The count decrements and the top moves to the previous entry.
  - ret_i only, empty: no pop; the PC goes sequential; the count stays 0.
  - call_i and ret_i together: next PC = current top when non-empty, else sequential. The top entry is replaced with pc_o + INC and the count is unchanged. On empty, this is a push.
- exc_i clears the RAS: count 0, pointers reset. Entries need not be zeroed.
- redir_i leaves the RAS unchanged. Mispredicted-return repair is out of scope.
- RAS state: a WIDTH × RAS_DEPTH array, a top pointer of clog2(RAS_DEPTH) bits wrapping modulo RAS_DEPTH, and a saturating count.

## Timing
- Reset (rst_i high, asynchronous): pc_o = RESET_VEC, ras_count_o = 0, ras_empty_o = 1, ras_full_o = 0. This takes effect immediately, without waiting for an edge.
- Reset release: the first edge with rst_i low performs a normal update. Reset asserted mid-operation discards RAS contents and any pending redirect.
- Latency: one cycle. pc_o equals the previous cycle's pc_next_o.
- pc_next_o is purely combinational from the inputs and the current state. It is valid the same cycle, with no internal registering.
- RAS status outputs are registered and reflect state after the last edge.
- Inputs need no handshake. They are sampled every edge and are level-qualified by priority.

## Test plan
- Reset and sequential run: assert rst_i mid-cycle, then release.
  - pc_o = 0 immediately on assertion.
  - pc_o steps 0, 4, 8, 0xC on successive edges.
  - With WIDTH=8 starting at 0xFC: next pc_o = 0x00.
- Stall vs redirect:
  - pc_o = 0x40, pc_write_i = 0 for 3 edges: pc_o holds 0x40.
  - Still stalled, redir_i with target 0x100: pc_o = 0x100 next edge.
  - exc_i and redir_i together with exc_vec_i = 0x80000180: pc_o = 0x80000180.
- Call/return:
  - call_i at pc 0x10, then run to 0x200.
  - ret_i at 0x200: pc_o = 0x14, ras_count_o goes 1 → 0.
  - ret_i on empty at 0x300: pc_o = 0x304.
- Overflow: RAS_DEPTH = 4, five calls at 0x00, 0x10, 0x20, 0x30, 0x40.
  - ras_full_o = 1, count = 4.
  - Four returns yield 0x44, 0x34, 0x24, 0x14.
  - A fifth return is sequential.
- Simultaneous call+ret and clearing:
  - Top = 0x14, call_i+ret_i at pc 0x50: pc_o = 0x14, top becomes 0x54, count unchanged.
  - exc_i afterwards: ras_empty_o = 1 next edge.
  - call_i with pc_write_i = 0: no push.
